// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Combinational next-PC prediction, trained from the resolve stage, with saturating statistics.
module btb_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int IDX_LSB = 2,
    parameter int PC_INC  = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush,
    output logic              mispredict,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_LSB - IDX_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];

    logic               r_mispredict;
    logic [CNT_W-1:0]   r_hit_count;
    logic [CNT_W-1:0]   r_mispred_count;

    logic [IDX_W-1:0]   w_lidx;
    logic [TAG_W-1:0]   w_ltag;
    logic               w_lhit;
    logic               w_ltaken;
    logic [IDX_W-1:0]   w_uidx;
    logic [TAG_W-1:0]   w_utag;
    logic               w_uhit;
    logic [1:0]         w_ucnt;
    logic [1:0]         w_cnt_next;
    logic               w_pred_dir;
    logic               w_mis_evt;
    logic               w_unused;

    assign w_lidx   = lookup_pc[IDX_LSB +: IDX_W];
    assign w_ltag   = lookup_pc[ADDR_W-1 -: TAG_W];
    assign w_lhit   = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign w_ltaken = w_lhit && r_cnt[w_lidx][1];

    assign pred_hit   = w_lhit;
    assign pred_taken = w_ltaken;
    assign pred_pc    = w_ltaken ? r_target[w_lidx] : lookup_pc + PC_STEP;

    assign w_uidx     = upd_pc[IDX_LSB +: IDX_W];
    assign w_utag     = upd_pc[ADDR_W-1 -: TAG_W];
    assign w_uhit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_ucnt     = r_cnt[w_uidx];
    assign w_pred_dir = w_uhit && w_ucnt[1];

    // Judged against the pre-update table, so flush does not hide the event.
    assign w_mis_evt = upd_valid &&
                       ((w_pred_dir != upd_taken) ||
                        (w_pred_dir && upd_taken && (r_target[w_uidx] != upd_target)));

    // The index bits below IDX_LSB never participate in lookup or update.
    assign w_unused = ^{lookup_pc, upd_pc};

    always_comb begin
        w_cnt_next = w_ucnt;
        if (upd_taken) begin
            if (w_ucnt != 2'd3) w_cnt_next = w_ucnt + 2'd1;
        end else begin
            if (w_ucnt != 2'd0) w_cnt_next = w_ucnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'd1;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (upd_valid) begin
            if (w_uhit) begin
                r_cnt[w_uidx] <= w_cnt_next;
                if (upd_taken) r_target[w_uidx] <= upd_target;
            end else if (upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd_target;
                r_cnt[w_uidx]    <= 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispredict    <= 1'b0;
            r_hit_count     <= '0;
            r_mispred_count <= '0;
        end else begin
            r_mispredict <= w_mis_evt;
            if (w_lhit && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_mis_evt && (r_mispred_count != '1))
                r_mispred_count <= r_mispred_count + CNT_W'(1);
        end
    end

    assign mispredict    = r_mispredict;
    assign hit_count     = r_hit_count;
    assign mispred_count = r_mispred_count;

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: a reference table model feeds a scoreboard of per-cycle expectations,
// and each scenario task also checks the combinational prediction against fixed values.
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [15:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [15:0] pred_pc;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        flush;
    logic        mispredict;
    logic [15:0] hit_count;
    logic [15:0] mispred_count;

    logic        smallHit;
    logic        smallTaken;
    logic [15:0] smallPc;
    logic        smallMis;
    logic [3:0]  smallHitCount;
    logic [3:0]  smallMisCount;

    int passed = 0;
    int total  = 0;
    int stepId = 0;

    typedef struct {
        logic        misp;
        logic [15:0] hc;
        logic [15:0] mc;
        logic [3:0]  hc4;
        int          id;
    } sbItem_t;

    sbItem_t sbQ[$];

    logic        mValid  [16];
    logic [9:0]  mTag    [16];
    logic [15:0] mTarget [16];
    logic [1:0]  mCnt    [16];
    logic [15:0] expHit;
    logic [15:0] expMis;
    logic [3:0]  expHit4;

    btb_predictor dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush), .mispredict(mispredict),
        .hit_count(hit_count), .mispred_count(mispred_count)
    );

    btb_predictor #(.CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(smallHit), .pred_taken(smallTaken), .pred_pc(smallPc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .flush(flush), .mispredict(smallMis),
        .hit_count(smallHitCount), .mispred_count(smallMisCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelHit(input logic [15:0] pc);
        return mValid[pc[5:2]] && (mTag[pc[5:2]] == pc[15:6]);
    endfunction

    // Scoreboard drain: every item was pushed in the cycle before this edge.
    always @(posedge clk) begin
        sbItem_t it;
        #1;
        if (sbQ.size() != 0) begin
            it = sbQ.pop_front();
            total++;
            if (mispredict !== it.misp)
                $display("[TB] FAIL mispredict step %0d: got %b want %b", it.id, mispredict, it.misp);
            else passed++;
            total++;
            if (hit_count !== it.hc)
                $display("[TB] FAIL hit_count step %0d: got %0d want %0d", it.id, hit_count, it.hc);
            else passed++;
            total++;
            if (mispred_count !== it.mc)
                $display("[TB] FAIL mispred_count step %0d: got %0d want %0d", it.id, mispred_count, it.mc);
            else passed++;
            total++;
            if (smallHitCount !== it.hc4)
                $display("[TB] FAIL hit_count_cnt4 step %0d: got %0d want %0d", it.id, smallHitCount, it.hc4);
            else passed++;
        end
    end

    // One clock cycle with rst low: drive, predict with the model, push expectations.
    task automatic step(input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                        input logic ut, input logic [15:0] utgt, input logic fl);
        sbItem_t    it;
        logic       lh, uh, pdir, mis;
        logic [3:0] ui;
        lookup_pc  = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utgt;
        flush      = fl;
        #1;
        lh   = modelHit(lpc);
        ui   = upc[5:2];
        uh   = modelHit(upc);
        pdir = uh && mCnt[ui][1];
        mis  = uv && ((pdir != ut) || (pdir && ut && (mTarget[ui] != utgt)));
        if (lh) begin
            if (expHit != 16'hFFFF) expHit = expHit + 16'd1;
            if (expHit4 != 4'hF) expHit4 = expHit4 + 4'd1;
        end
        if (mis && expMis != 16'hFFFF) expMis = expMis + 16'd1;
        it.misp = mis;
        it.hc   = expHit;
        it.mc   = expMis;
        it.hc4  = expHit4;
        it.id   = stepId;
        sbQ.push_back(it);
        stepId++;
        if (fl) begin
            for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        end else if (uv) begin
            if (uh) begin
                if (ut) begin
                    if (mCnt[ui] != 2'd3) mCnt[ui] = mCnt[ui] + 2'd1;
                    mTarget[ui] = utgt;
                end else if (mCnt[ui] != 2'd0) begin
                    mCnt[ui] = mCnt[ui] - 2'd1;
                end
            end else if (ut) begin
                mValid[ui]  = 1'b1;
                mTag[ui]    = upc[15:6];
                mTarget[ui] = utgt;
                mCnt[ui]    = 2'd2;
            end
        end
        @(negedge clk);
        upd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        lookup_pc  = 16'h0010;
        upd_valid  = 1'b1;
        upd_pc     = 16'h0010;
        upd_taken  = 1'b1;
        upd_target = 16'h0200;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        upd_valid = 1'b0;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b0, 1'b0, 16'h0014})
            $display("[TB] FAIL reset_lookup: got %b/%b/%h want 0/0/0014", pred_hit, pred_taken, pred_pc);
        else passed++;
        total++;
        if ({mispredict, hit_count, mispred_count} !== 33'd0)
            $display("[TB] FAIL reset_stats: got %b/%0d/%0d want 0/0/0", mispredict, hit_count, mispred_count);
        else passed++;
        total++;
        if (smallHitCount !== 4'd0)
            $display("[TB] FAIL reset_cnt4: got %0d want 0", smallHitCount);
        else passed++;
        for (int i = 0; i < 16; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = '0;
            mTarget[i] = '0;
            mCnt[i]    = 2'd1;
        end
        expHit  = '0;
        expMis  = '0;
        expHit4 = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_allocate;
        step(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0200, 1'b0);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b1, 16'h0200})
            $display("[TB] FAIL alloc_lookup: got %b/%b/%h want 1/1/0200", pred_hit, pred_taken, pred_pc);
        else passed++;
        step(16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_counter;
        step(16'h0010, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b0, 16'h0014})
            $display("[TB] FAIL weak_nt_lookup: got %b/%b/%h want 1/0/0014", pred_hit, pred_taken, pred_pc);
        else passed++;
        for (int k = 0; k < 3; k++)
            step(16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0200, 1'b0);
        step(16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b1, 16'h0200})
            $display("[TB] FAIL sat_high_lookup: got %b/%b/%h want 1/1/0200", pred_hit, pred_taken, pred_pc);
        else passed++;
        step(16'h0000, 1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b0, 16'h0014})
            $display("[TB] FAIL drop_to_weak_nt: got %b/%b/%h want 1/0/0014", pred_hit, pred_taken, pred_pc);
        else passed++;
    endtask

    task automatic test_alias;
        step(16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0200, 1'b0);
        step(16'h0000, 1'b1, 16'h0050, 1'b1, 16'h0300, 1'b0);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b0, 1'b0, 16'h0014})
            $display("[TB] FAIL alias_old: got %b/%b/%h want 0/0/0014", pred_hit, pred_taken, pred_pc);
        else passed++;
        lookup_pc = 16'h0050;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b1, 16'h0300})
            $display("[TB] FAIL alias_new: got %b/%b/%h want 1/1/0300", pred_hit, pred_taken, pred_pc);
        else passed++;
        step(16'h0050, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_wrong_target;
        step(16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0200, 1'b0);
        step(16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0280, 1'b0);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b1, 16'h0280})
            $display("[TB] FAIL new_target: got %b/%b/%h want 1/1/0280", pred_hit, pred_taken, pred_pc);
        else passed++;
    endtask

    task automatic test_back_to_back;
        lookup_pc  = 16'h0020;
        upd_valid  = 1'b1;
        upd_pc     = 16'h0020;
        upd_taken  = 1'b1;
        upd_target = 16'h0400;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b0, 1'b0, 16'h0024})
            $display("[TB] FAIL same_cycle_old: got %b/%b/%h want 0/0/0024", pred_hit, pred_taken, pred_pc);
        else passed++;
        step(16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0400, 1'b0);
        step(16'h0020, 1'b1, 16'h0020, 1'b1, 16'h0400, 1'b0);
        lookup_pc = 16'h0020;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b1, 1'b1, 16'h0400})
            $display("[TB] FAIL b2b_lookup: got %b/%b/%h want 1/1/0400", pred_hit, pred_taken, pred_pc);
        else passed++;
    endtask

    task automatic test_flush;
        step(16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0300, 1'b1);
        lookup_pc = 16'h0010;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b0, 1'b0, 16'h0014})
            $display("[TB] FAIL flush_0010: got %b/%b/%h want 0/0/0014", pred_hit, pred_taken, pred_pc);
        else passed++;
        lookup_pc = 16'h0020;
        #1;
        total++;
        if ({pred_hit, pred_taken, pred_pc} !== {1'b0, 1'b0, 16'h0024})
            $display("[TB] FAIL flush_0020: got %b/%b/%h want 0/0/0024", pred_hit, pred_taken, pred_pc);
        else passed++;
        step(16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_saturation;
        test_reset();
        step(16'h0100, 1'b1, 16'h0030, 1'b1, 16'h0600, 1'b0);
        for (int k = 0; k < 20; k++)
            step(16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        total++;
        if (smallHitCount !== 4'hF)
            $display("[TB] FAIL cnt4_saturate: got %0d want 15", smallHitCount);
        else passed++;
        total++;
        if (hit_count !== 16'd20)
            $display("[TB] FAIL cnt16_hits: got %0d want 20", hit_count);
        else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        lookup_pc  = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        flush      = 1'b0;
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_wrong_target();
        test_back_to_back();
        test_flush();
        test_saturation();
        @(negedge clk);
        total++;
        if (sbQ.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d pending want 0", sbQ.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
